// File: rtl/adder_serial1.sv
// adder_serial1 -- one-bit full-adder cell plus a clocked bit-serial adder.
//
// The combinational cell (x, y, c_in -> sum, c_out) is the per-bit building
// block of ripple-carry adders. The serial engine reuses the same full-adder
// equations with a registered carry. It adds two WORD_W-bit operands
// LSB-first, one bit pair per enabled cycle.
//
// Ports:
//   clk        clock, all registers update on the rising edge
//   rst        synchronous active-high reset
//   x, y       operand bits, shared by both paths
//   c_in       carry-in; the serial path samples it only on ser_start
//   sum, c_out combinational full-adder outputs
//   ser_start  begin (or restart) a serial addition
//   ser_en     present one operand bit pair this cycle
//   ser_sum    registered sum bit of the last enabled step
//   ser_busy   serial addition in progress
//   ser_done   one-cycle pulse when the word completes
//   ser_word   completed sum word, LSB = first bit
//   ser_cout   final carry of the completed word
//
// state  | meaning
// S_IDLE | no word in progress; ser_en is ignored
// S_BUSY | accepting bit pairs until WORD_W have been consumed

module adder_serial1 #(
    parameter int WORD_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              x,
    input  logic              y,
    input  logic              c_in,
    output logic              sum,
    output logic              c_out,
    input  logic              ser_start,
    input  logic              ser_en,
    output logic              ser_sum,
    output logic              ser_busy,
    output logic              ser_done,
    output logic [WORD_W-1:0] ser_word,
    output logic              ser_cout
);

    localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              carry_q;
    logic [CNT_W-1:0]  cnt;
    logic [WORD_W-1:0] word_q;
    logic [WORD_W-1:0] word_shift;
    logic              done_q;
    logic              sum_q;
    logic              cout_q;
    logic              step;
    logic              last_step;
    logic              s_bit;
    logic              c_bit;

    // Combinational cell.
    assign sum   = x ^ y ^ c_in;
    assign c_out = (x & y) | (c_in & (x ^ y));

    // Serial full adder against the registered carry.
    assign s_bit = x ^ y ^ carry_q;
    assign c_bit = (x & y) | (carry_q & (x ^ y));

    assign step      = ser_en && (state_q == S_BUSY) && !ser_start;
    assign last_step = step && (cnt == CNT_LAST);

    // Shift right and insert the new bit at the top; written this way so
    // it also covers WORD_W = 1 without an empty part-select.
    always_comb begin
        word_shift             = word_q >> 1;
        word_shift[WORD_W-1]   = s_bit;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; start has priority and also aborts a running word.
    always_comb begin
        state_d = state_q;
        if (ser_start)      state_d = S_BUSY;
        else if (last_step) state_d = S_IDLE;
    end

    // Output logic.
    always_comb begin
        ser_busy = (state_q == S_BUSY);
        ser_done = done_q;
        ser_sum  = sum_q;
        ser_word = word_q;
        ser_cout = cout_q;
    end

    // Serial datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            carry_q <= 1'b0;
            cnt     <= '0;
            word_q  <= '0;
            done_q  <= 1'b0;
            sum_q   <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (ser_start) begin
                carry_q <= c_in;
                cnt     <= '0;
                word_q  <= '0;
            end else if (step) begin
                carry_q <= c_bit;
                sum_q   <= s_bit;
                word_q  <= word_shift;
                cnt     <= cnt + 1'b1;
                if (last_step) begin
                    done_q <= 1'b1;
                    cout_q <= c_bit;
                end
            end
        end
    end

endmodule

// File: tb/tb_adder_serial1.sv
// Directed testbench for adder_serial1 (WORD_W = 4).
module tb_adder_serial1;

    logic       clk = 1'b0;
    logic       rst;
    logic       x, y, c_in;
    logic       sum, c_out;
    logic       ser_start, ser_en;
    logic       ser_sum, ser_busy, ser_done, ser_cout;
    logic [3:0] ser_word;

    int n_cmp = 0;
    int n_err = 0;

    adder_serial1 #(.WORD_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .x         (x),
        .y         (y),
        .c_in      (c_in),
        .sum       (sum),
        .c_out     (c_out),
        .ser_start (ser_start),
        .ser_en    (ser_en),
        .ser_sum   (ser_sum),
        .ser_busy  (ser_busy),
        .ser_done  (ser_done),
        .ser_word  (ser_word),
        .ser_cout  (ser_cout)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one enabled bit pair for one cycle.
    task automatic en_bit(input logic a, input logic b);
        ser_start = 1'b0;
        ser_en    = 1'b1;
        x         = a;
        y         = b;
        tick();
        ser_en    = 1'b0;
    endtask

    task automatic start_word(input logic cin);
        ser_start = 1'b1;
        ser_en    = 1'b0;
        c_in      = cin;
        tick();
        ser_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ser_start = 1'b1; ser_en = 1'b1;
        x = 1'b1; y = 1'b1; c_in = 1'b1;
        tick(); tick();
        ser_start = 1'b0; ser_en = 1'b0;
        tick();
        n_cmp++;
        if ({ser_sum, ser_busy, ser_done, ser_cout, ser_word} !== 8'h00) begin
            n_err++;
            $display("FAIL reset_state: got %b required 00000000",
                     {ser_sum, ser_busy, ser_done, ser_cout, ser_word});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_comb();
        logic [7:0] sum_tab  = 8'b1001_0110;
        logic [7:0] cout_tab = 8'b1110_1000;
        for (int i = 0; i < 8; i++) begin
            {x, y, c_in} = 3'(i);
            #1;
            n_cmp++;
            if (sum !== sum_tab[i] || c_out !== cout_tab[i]) begin
                n_err++;
                $display("FAIL comb_xyc=%03b: got sum %b c_out %b required sum %b c_out %b",
                         3'(i), sum, c_out, sum_tab[i], cout_tab[i]);
            end
        end
    endtask

    // Rippled 4-bit add built from the single cell, one bit at a time.
    task automatic test_ripple();
        logic [3:0] a_v   [4] = '{4'b0000, 4'b0001, 4'b0001, 4'b0001};
        logic [3:0] b_v   [4] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001};
        logic       ci_v  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [3:0] r_v   [4] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011};
        logic       co_v  [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
        logic [3:0] r;
        logic       c;
        for (int v = 0; v < 4; v++) begin
            c = ci_v[v];
            for (int b = 0; b < 4; b++) begin
                x = a_v[v][b]; y = b_v[v][b]; c_in = c;
                #1;
                r[b] = sum;
                c    = c_out;
            end
            n_cmp++;
            if (r !== r_v[v] || c !== co_v[v]) begin
                n_err++;
                $display("FAIL ripple_%0d: got %b c %b required %b c %b",
                         v, r, c, r_v[v], co_v[v]);
            end
        end
    endtask

    // 0111 + 0001 + 0 on consecutive cycles.
    task automatic test_serial_basic();
        logic [3:0] a = 4'b0111;
        logic [3:0] b = 4'b0001;
        logic [3:0] s_exp = 4'b1000;
        start_word(1'b0);
        n_cmp++;
        if (ser_busy !== 1'b1 || ser_done !== 1'b0) begin
            n_err++;
            $display("FAIL basic_start: got busy %b done %b required 1 0", ser_busy, ser_done);
        end
        for (int i = 0; i < 4; i++) begin
            en_bit(a[i], b[i]);
            n_cmp++;
            if (ser_sum !== s_exp[i]) begin
                n_err++;
                $display("FAIL basic_bit%0d: got ser_sum %b required %b", i, ser_sum, s_exp[i]);
            end
            if (i < 3) begin
                n_cmp++;
                if (ser_busy !== 1'b1 || ser_done !== 1'b0) begin
                    n_err++;
                    $display("FAIL basic_mid%0d: got busy %b done %b required 1 0",
                             i, ser_busy, ser_done);
                end
            end
        end
        n_cmp++;
        if (ser_done !== 1'b1 || ser_busy !== 1'b0 || ser_word !== 4'b1000 || ser_cout !== 1'b0) begin
            n_err++;
            $display("FAIL basic_done: got done %b busy %b word %b cout %b required 1 0 1000 0",
                     ser_done, ser_busy, ser_word, ser_cout);
        end
        tick();
        n_cmp++;
        if (ser_done !== 1'b0 || ser_word !== 4'b1000 || ser_cout !== 1'b0) begin
            n_err++;
            $display("FAIL basic_hold: got done %b word %b cout %b required 0 1000 0",
                     ser_done, ser_word, ser_cout);
        end
    endtask

    // 1111 + 0001 + 0 with two idle cycles after every bit.
    task automatic test_gaps();
        logic [3:0] a = 4'b1111;
        logic [3:0] b = 4'b0001;
        start_word(1'b0);
        for (int i = 0; i < 4; i++) begin
            en_bit(a[i], b[i]);
            if (i < 3) begin
                tick(); tick();
                n_cmp++;
                if (ser_busy !== 1'b1 || ser_done !== 1'b0) begin
                    n_err++;
                    $display("FAIL gap_busy%0d: got busy %b done %b required 1 0",
                             i, ser_busy, ser_done);
                end
            end
        end
        n_cmp++;
        if (ser_done !== 1'b1 || ser_word !== 4'b0000 || ser_cout !== 1'b1) begin
            n_err++;
            $display("FAIL gap_done: got done %b word %b cout %b required 1 0000 1",
                     ser_done, ser_word, ser_cout);
        end
    endtask

    // Start+en together: that pair (1,1) is dropped; 0101 + 0011 follows.
    task automatic test_start_with_en();
        logic [3:0] a = 4'b0101;
        logic [3:0] b = 4'b0011;
        ser_start = 1'b1; ser_en = 1'b1; x = 1'b1; y = 1'b1; c_in = 1'b0;
        tick();
        ser_start = 1'b0; ser_en = 1'b0;
        for (int i = 0; i < 3; i++) en_bit(a[i], b[i]);
        n_cmp++;
        if (ser_busy !== 1'b1 || ser_done !== 1'b0) begin
            n_err++;
            $display("FAIL start_en_3steps: got busy %b done %b required 1 0", ser_busy, ser_done);
        end
        en_bit(a[3], b[3]);
        n_cmp++;
        if (ser_done !== 1'b1 || ser_word !== 4'b1000 || ser_cout !== 1'b0) begin
            n_err++;
            $display("FAIL start_en_done: got done %b word %b cout %b required 1 1000 0",
                     ser_done, ser_word, ser_cout);
        end
        en_bit(1'b1, 1'b1);
        en_bit(1'b1, 1'b0);
        n_cmp++;
        if (ser_word !== 4'b1000 || ser_busy !== 1'b0 || ser_done !== 1'b0 || ser_sum !== 1'b1) begin
            n_err++;
            $display("FAIL idle_en: got word %b busy %b done %b sum %b required 1000 0 0 1",
                     ser_word, ser_busy, ser_done, ser_sum);
        end
    endtask

    // Reset after two bits, then a fresh 0011 + 0011 + 1.
    task automatic test_reset_mid();
        logic [3:0] a = 4'b0011;
        logic       saw_done = 1'b0;
        start_word(1'b0);
        en_bit(1'b1, 1'b1);
        en_bit(1'b1, 1'b1);
        rst = 1'b1; ser_en = 1'b1; ser_start = 1'b1; x = 1'b1; y = 1'b1;
        tick();
        rst = 1'b0; ser_en = 1'b0; ser_start = 1'b0;
        n_cmp++;
        if ({ser_sum, ser_busy, ser_done, ser_cout, ser_word} !== 8'h00) begin
            n_err++;
            $display("FAIL reset_mid: got %b required 00000000",
                     {ser_sum, ser_busy, ser_done, ser_cout, ser_word});
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (ser_done) saw_done = 1'b1;
        end
        n_cmp++;
        if (saw_done !== 1'b0 || ser_busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_nodone: got done_seen %b busy %b required 0 0",
                     saw_done, ser_busy);
        end
        start_word(1'b1);
        for (int i = 0; i < 4; i++) en_bit(a[i], a[i]);
        n_cmp++;
        if (ser_done !== 1'b1 || ser_word !== 4'b0111 || ser_cout !== 1'b0) begin
            n_err++;
            $display("FAIL reset_fresh: got done %b word %b cout %b required 1 0111 0",
                     ser_done, ser_word, ser_cout);
        end
    endtask

    // Restart mid-word: carry-in 1 and two bits of the aborted word must not leak.
    task automatic test_back_to_back();
        start_word(1'b1);
        en_bit(1'b1, 1'b1);
        en_bit(1'b1, 1'b1);
        start_word(1'b0);
        n_cmp++;
        if (ser_busy !== 1'b1 || ser_word !== 4'b0000) begin
            n_err++;
            $display("FAIL restart_clear: got busy %b word %b required 1 0000", ser_busy, ser_word);
        end
        for (int i = 0; i < 4; i++) en_bit(1'b1, 1'b1);
        n_cmp++;
        if (ser_done !== 1'b1 || ser_word !== 4'b1110 || ser_cout !== 1'b1) begin
            n_err++;
            $display("FAIL restart_done: got done %b word %b cout %b required 1 1110 1",
                     ser_done, ser_word, ser_cout);
        end
        // Immediate next word right after done: 0000 + 0000 + 1.
        start_word(1'b1);
        n_cmp++;
        if (ser_done !== 1'b0 || ser_word !== 4'b0000 || ser_cout !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_start: got done %b word %b cout %b required 0 0000 1",
                     ser_done, ser_word, ser_cout);
        end
        for (int i = 0; i < 4; i++) en_bit(1'b0, 1'b0);
        n_cmp++;
        if (ser_done !== 1'b1 || ser_word !== 4'b0001 || ser_cout !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_done: got done %b word %b cout %b required 1 0001 0",
                     ser_done, ser_word, ser_cout);
        end
    endtask

    initial begin
        rst = 1'b1; x = 1'b0; y = 1'b0; c_in = 1'b0;
        ser_start = 1'b0; ser_en = 1'b0;
        test_reset();
        test_comb();
        test_ripple();
        test_serial_basic();
        test_gaps();
        test_start_with_en();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/adder_serial1.md
# adder_serial1

One-bit full-adder cell with an optional clocked bit-serial engine. The combinational port (x, y, c_in → sum, c_out) is the cell that wider ripple-carry adders instantiate once per bit, chaining c_out to the next bit's c_in. The serial engine reuses the same full-adder logic with a registered carry. It adds two WORD_W-bit operands LSB-first, one bit per enabled cycle.

## Interface
- WORD_W, default 4: serial word length in bits (≥1).

- clk  input  1  single clock; all registers update on its rising edge
- rst  input  1  reset; synchronous and active-high
- x  input  1  operand bit A, shared by both paths
- y  input  1  operand bit B, shared by both paths
- c_in  input  1  carry-in; in the serial path it is sampled only on ser_start
- sum  output  1  combinational sum bit
- c_out  output  1  combinational carry-out
- ser_start  input  1  begin a serial addition
- ser_en  input  1  present one operand bit pair (x, y) this cycle
- ser_sum  output  1  registered sum bit of the last enabled step
- ser_busy  output  1  serial addition in progress
- ser_done  output  1  single-cycle pulse when the word is complete
- ser_word  output  WORD_W  completed sum word, LSB = first bit
- ser_cout  output  1  final carry of the completed word

## Operation
- Combinational path, independent of clk and rst:
  - sum = x ^ y ^ c_in
  - c_out = (x & y) | (c_in & (x ^ y))
- Serial registers: carry_q, cnt (0..WORD_W-1), word_q, busy, done, ser_sum, cout_q.
- ser_start = 1 (priority over ser_en in the same cycle; ser_en is ignored that cycle):
  - carry_q ← c_in
  - cnt ← 0
  - word_q ← 0
  - busy ← 1, done ← 0
  - A start while busy aborts the current word and restarts.
- ser_en = 1 with busy = 1 and no start:
  - s = x ^ y ^ carry_q; carry_q ← maj(x, y, carry_q)
  - ser_sum ← s
  - word_q ← {s, word_q[WORD_W-1:1]}, so after WORD_W steps the first bit sits at bit 0
  - cnt ← cnt + 1
- On the step where cnt = WORD_W-1:
  - busy ← 0
  - done ← 1
  - cout_q ← new carry
- ser_en with busy = 0 is ignored; all serial registers hold.
- ser_en = 0 while busy: all serial state holds. Gaps between bits are legal.
- ser_word = word_q and ser_cout = cout_q. Both hold after done until the next ser_start clears word_q; cout_q holds until the next completion.
- WORD_W = 1: a single enabled step completes the word.

## Timing
- Combinational path: zero-cycle latency, purely combinational.
- rst = 1 at a rising edge clears every register to 0: ser_sum, ser_busy, ser_done, ser_word, ser_cout, carry_q, cnt. Reset overrides start and en.
- Reset mid-word abandons the word. No done pulse is produced.
- ser_start at edge N: ser_busy = 1 after edge N.
- Enabled bit k (0-based) at edge M: ser_sum is valid after edge M.
- Final enabled bit at edge M: after edge M, ser_done = 1, ser_busy = 0, and ser_word and ser_cout are valid. ser_done returns to 0 after edge M+1 unless a new word completes.
- Minimum word latency: 1 start cycle + WORD_W enabled cycles.
- ser_start and rst are level-sampled each edge. Holding ser_start high keeps re-initialising.

## Test plan
- Combinational exhaustive check of all 8 (x, y, c_in) combinations. Examples: (1,1,1) → sum 1, c_out 1; (1,0,0) → sum 1, c_out 0.
- Four cells rippled as a 4-bit adder:
  - 0000 + 0000 + 0 → 0000, c_out 0
  - 0001 + 0000 + 0 → 0001, c_out 0
  - 0001 + 0001 + 0 → 0010, c_out 0
  - 0001 + 0001 + 1 → 0011, c_out 0
- Serial, WORD_W = 4: start with c_in = 0, then feed 0111 + 0001 LSB-first on 4 consecutive ser_en cycles → ser_word 1000, ser_cout 0, one-cycle ser_done after the 4th step.
- Serial: 1111 + 0001, c_in = 0, with idle cycles (ser_en = 0) between bits → ser_word 0000, ser_cout 1. ser_busy stays 1 through the gaps.
- Start and en in the same cycle: that (x, y) is ignored, and 4 further enabled steps are still required. ser_en while idle leaves ser_word unchanged.
- rst asserted after 2 of 4 serial bits → all outputs 0 on the next cycle and no ser_done. A fresh start completes correctly: 0011 + 0011 + 1 → 0111, ser_cout 0.
